// File: rtl/frame_reader_pkg.sv
// Shared definitions for the frame reader: FSM encoding, default output-image
// geometry and the channel-sum helper used by the optional FRAME_SUM_EN checksum.
package frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int IMG_W_DEF = 300;
  localparam int IMG_H_DEF = 300;
  localparam int BASE_DEF  = 302;
  localparam int COORD_W   = 16;

  function automatic logic [31:0] chan_sum(input logic [23:0] w);
    return 32'(w[7:0]) + 32'(w[15:8]) + 32'(w[23:16]);
  endfunction

endpackage

// File: rtl/frame_reader_pix_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible on rdata whenever the
// FIFO is not empty; a pop advances to the next entry.
module pix_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Streams the processed output image out of the pixel memory as a valid/ready
// raster stream with frame markers. Optional checksum port under FRAME_SUM_EN.
//
// state | meaning
// IDLE  | waiting for start; no reads, stream idle
// READ  | issuing reads BASE..BASE+NPIX-1 under FIFO credit
// DRAIN | all reads issued; emptying FIFO until last pixel handshake
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int BASE  = BASE_DEF,
  parameter int NPIX  = IMG_W_DEF * IMG_H_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   mem_a,
  input  logic [WIDTH-1:0]   mem_rd,
  output logic [WIDTH-1:0]   pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               sof,
  output logic               eol,
  output logic               eof
`ifdef FRAME_SUM_EN
  ,
  output logic [31:0]        frame_sum
`endif
);

  localparam int IW = $clog2(NPIX + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t             state, state_nxt;
  logic [IW-1:0]      rd_idx, out_idx;
  logic [COORD_W-1:0] x_q, y_q;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty;
  logic               issued_q, issue, accept, hs, last_issue, last_hs, done_q;

  assign accept     = (state == IDLE) && start;
  assign hs         = pix_valid && pix_ready;
  assign last_issue = issue && (rd_idx == IW'(NPIX - 1));
  assign last_hs    = hs && (out_idx == IW'(NPIX - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = READ;
      READ:    if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_hs)    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // A read is in flight for one cycle, so it must be counted against FIFO space.
  always_comb begin
    busy  = (state != IDLE);
    issue = (state == READ) && ((int'(fifo_count) + int'(issued_q)) < DEPTH);
    mem_a = WIDTH'(BASE) + WIDTH'(rd_idx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_idx   <= '0;
      out_idx  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      issued_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      issued_q <= issue;
      done_q   <= (state == DRAIN) && last_hs;
      if (accept) begin
        rd_idx  <= '0;
        out_idx <= '0;
        x_q     <= '0;
        y_q     <= '0;
      end else begin
        // rd_idx parks on the last address so mem_a holds through DRAIN.
        if (issue && !last_issue) rd_idx <= rd_idx + IW'(1);
        if (hs) begin
          out_idx <= out_idx + IW'(1);
          if (x_q == COORD_W'(IMG_W - 1)) begin
            x_q <= '0;
            y_q <= y_q + COORD_W'(1);
          end else begin
            x_q <= x_q + COORD_W'(1);
          end
        end
      end
    end
  end

  pix_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issued_q),
    .wdata (mem_rd),
    .pop   (hs),
    .rdata (pix_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(issued_q && fifo_full && !hs))
    else $error("frame_reader: FIFO push while full");

  assign done      = done_q;
  assign pix_valid = !fifo_empty;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign sof       = pix_valid && (out_idx == '0);
  assign eol       = pix_valid && (x_q == COORD_W'(IMG_W - 1));
  assign eof       = pix_valid && (out_idx == IW'(NPIX - 1));

`ifdef FRAME_SUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      frame_sum <= '0;
    else if (accept) frame_sum <= '0;
    else if (hs)     frame_sum <= frame_sum + chan_sum(pix_data[23:0]);
  end
`endif

endmodule
